// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetch/decode/sequence stage feeding a 4-bit ALU.
// Fetches {opcode, imm} bytes, drives ALU opcode/operands for ALU_LAT cycles,
// writes results back into a 4-bit accumulator and latches the ALU flags.
// LDI/JMP/JEQ/HLT and NOPs are handled locally in a single EXEC cycle.
//
// Ports:
//   clk, reset (async, active-low)
//   fetch_req / pc_out           - instruction request and current PC
//   instr_in / instr_valid       - instruction word and its valid strobe
//   step (SINGLE_STEP_EN only)   - FETCH also waits for step=1
//   alu_opcode/alu_a/alu_b       - ALU operation and operands (NOP outside EXEC/WB)
//   alu_result / alu_flag        - ALU outputs, consumed in WB
//   acc_out / flag_out / halted  - architectural state
//
// Build option: define SINGLE_STEP_EN to add the step input.

module instruction_sequencer #(
    parameter int unsigned PC_W     = 4,
    parameter int unsigned ALU_LAT  = 2,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            fetch_req,
    output logic [PC_W-1:0] pc_out,
    input  logic [7:0]      instr_in,
    input  logic            instr_valid,
`ifdef SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic [3:0]      alu_opcode,
    output logic [3:0]      alu_a,
    output logic [3:0]      alu_b,
    input  logic [3:0]      alu_result,
    input  logic [4:0]      alu_flag,
    output logic [3:0]      acc_out,
    output logic [4:0]      flag_out,
    output logic            halted
);

    localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);

    localparam logic [3:0] OP_CMP = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JEQ = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        WB    = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [PC_W-1:0]   pc, pc_n;
    logic [3:0]        acc, acc_n;
    logic [4:0]        flag_q, flag_n;
    logic [7:0]        ir, ir_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              fetch_req_n, halted_n, alu_active;
    logic [3:0]        alu_opcode_n, alu_b_n;
    logic              fetch_go;

    // Opcodes 1..6 are executed by the external ALU.
    function automatic logic is_alu(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'h6);
    endfunction

`ifdef SINGLE_STEP_EN
    assign fetch_go = instr_valid & step;
`else
    assign fetch_go = instr_valid;
`endif

    // Next-state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        acc_n   = acc;
        flag_n  = flag_q;
        ir_n    = ir;
        cnt_n   = cnt;
        case (state)
            FETCH: begin
                if (fetch_go) begin
                    ir_n    = instr_in;
                    pc_n    = pc + PC_W'(1);
                    cnt_n   = '0;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (is_alu(ir[7:4])) begin
                    // Hold the ALU inputs for ALU_LAT cycles before writeback.
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        state_n = WB;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end else begin
                    state_n = FETCH;
                    case (ir[7:4])
                        OP_LDI: acc_n = ir[3:0];
                        OP_JMP: pc_n  = PC_W'(ir[3:0]);
                        OP_JEQ: if (flag_q[2]) pc_n = PC_W'(ir[3:0]);
                        OP_HLT: state_n = HALT;
                        default: ;
                    endcase
                end
            end
            WB: begin
                flag_n = alu_flag;
                if (ir[7:4] != OP_CMP) acc_n = alu_result;
                state_n = FETCH;
            end
            HALT: ;
            default: state_n = FETCH;
        endcase

        fetch_req_n  = (state_n == FETCH);
        halted_n     = (state_n == HALT);
        alu_active   = ((state_n == EXEC) || (state_n == WB)) && is_alu(ir_n[7:4]);
        alu_opcode_n = alu_active ? ir_n[7:4] : 4'h0;
        alu_b_n      = alu_active ? ir_n[3:0] : 4'h0;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            pc         <= PC_W'(RESET_PC);
            acc        <= 4'h0;
            flag_q     <= 5'h0;
            ir         <= 8'h0;
            cnt        <= '0;
            fetch_req  <= 1'b1;
            halted     <= 1'b0;
            alu_opcode <= 4'h0;
            alu_b      <= 4'h0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            acc        <= acc_n;
            flag_q     <= flag_n;
            ir         <= ir_n;
            cnt        <= cnt_n;
            fetch_req  <= fetch_req_n;
            halted     <= halted_n;
            alu_opcode <= alu_opcode_n;
            alu_b      <= alu_b_n;
        end
    end

    assign pc_out   = pc;
    assign acc_out  = acc;
    assign alu_a    = acc;
    assign flag_out = flag_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer with an attached 4-bit ALU model.
// Per-instruction expectations go through a scoreboard queue and are checked
// when the instruction retires (fetch_req or halted returns).

module tb_instruction_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       fetch_req;
    logic [3:0] pc_out;
    logic [7:0] instr_in;
    logic       instr_valid;
`ifdef SINGLE_STEP_EN
    logic       step;
`endif
    logic [3:0] alu_opcode, alu_a, alu_b, alu_result;
    logic [4:0] alu_flag;
    logic [3:0] acc_out;
    logic [4:0] flag_out;
    logic       halted;

    int checks   = 0;
    int failures = 0;
    int step_id  = 0;

    typedef struct {
        logic [3:0] acc;
        logic [3:0] pc;
        logic [4:0] flag;
        logic [3:0] op;
        logic [3:0] b;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    instruction_sequencer #(.PC_W(4), .ALU_LAT(2), .RESET_PC(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .pc_out      (pc_out),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
`ifdef SINGLE_STEP_EN
        .step        (step),
`endif
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_flag    (alu_flag),
        .acc_out     (acc_out),
        .flag_out    (flag_out),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Attached ALU: {less, greater, equal, carry(ADD), borrow(SUB)}.
    logic [4:0] add5, sub5;
    always_comb begin
        add5       = {1'b0, alu_a} + {1'b0, alu_b};
        sub5       = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = 4'h0;
        case (alu_opcode)
            4'h1:       alu_result = add5[3:0];
            4'h2, 4'h6: alu_result = sub5[3:0];
            4'h3:       alu_result = alu_a & alu_b;
            4'h4:       alu_result = alu_a | alu_b;
            4'h5:       alu_result = alu_a ^ alu_b;
            default:    ;
        endcase
        alu_flag = {alu_a < alu_b, alu_a > alu_b, alu_a == alu_b,
                    (alu_opcode == 4'h1) && add5[4],
                    (alu_opcode == 4'h2) && sub5[4]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL step%0d %s observed=%0h expected=%0h", step_id, tag, obs, exp_v);
        end
    endtask

    task automatic set_strobe(input logic v);
        instr_valid = v;
`ifdef SINGLE_STEP_EN
        step = v;
`endif
    endtask

    // Issue one instruction, then compare architectural state at retirement.
    task automatic do_instr(input logic [7:0] ins, input logic [3:0] e_acc,
                            input logic [3:0] e_pc, input logic [4:0] e_flag, input int e_cyc);
        exp_t e, g;
        int   cyc;
        int   n;
        logic [3:0] op0, b0;
        logic alu_ins;
        step_id++;
        alu_ins = (ins[7:4] >= 4'h1) && (ins[7:4] <= 4'h6);
        e.acc  = e_acc;
        e.pc   = e_pc;
        e.flag = e_flag;
        e.op   = alu_ins ? ins[7:4] : 4'h0;
        e.b    = alu_ins ? ins[3:0] : 4'h0;
        e.cyc  = e_cyc;
        sb.push_back(e);
        n = 0;
        while (fetch_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (fetch_req !== 1'b1) check("fetch_wait", 32'(fetch_req), 32'd1);
        instr_in = ins;
        set_strobe(1'b1);
        @(negedge clk);
        set_strobe(1'b0);
        op0 = alu_opcode;
        b0  = alu_b;
        cyc = 1;
        while (fetch_req !== 1'b1 && halted !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        g = sb.pop_front();
        check("exec_opcode", 32'(op0), 32'(g.op));
        check("exec_alu_b", 32'(b0), 32'(g.b));
        check("cycles", 32'(cyc), 32'(g.cyc));
        check("acc", 32'(acc_out), 32'(g.acc));
        check("pc", 32'(pc_out), 32'(g.pc));
        check("flag", 32'(flag_out), 32'(g.flag));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        instr_in = 8'h00;
        set_strobe(1'b0);
        repeat (2) @(negedge clk);
        check("rst_fetch_req", 32'(fetch_req), 32'd1);
        check("rst_pc", 32'(pc_out), 32'd0);
        check("rst_acc", 32'(acc_out), 32'd0);
        check("rst_flag", 32'(flag_out), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Load, add, compare and conditional jumps.
        do_instr(8'h75, 4'h5, 4'h1, 5'b00000, 2);
        do_instr(8'h13, 4'h8, 4'h2, 5'b01000, 4);
        do_instr(8'h73, 4'h3, 4'h3, 5'b01000, 2);
        do_instr(8'h63, 4'h3, 4'h4, 5'b00100, 4);
        do_instr(8'h9A, 4'h3, 4'hA, 5'b00100, 2);
        do_instr(8'h73, 4'h3, 4'hB, 5'b00100, 2);
        do_instr(8'h64, 4'h3, 4'hC, 5'b10000, 4);
        do_instr(8'h9A, 4'h3, 4'hD, 5'b10000, 2);

        // Fetch stall: five cycles without instr_valid.
        step_id++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_fetch_req", 32'(fetch_req), 32'd1);
            check("stall_pc", 32'(pc_out), 32'hD);
        end
        do_instr(8'h00, 4'h3, 4'hE, 5'b10000, 2);

        // Jump to the top of the map, PC wrap, undefined opcode.
        do_instr(8'h8F, 4'h3, 4'hF, 5'b10000, 2);
        do_instr(8'h00, 4'h3, 4'h0, 5'b10000, 2);
        do_instr(8'hC5, 4'h3, 4'h1, 5'b10000, 2);

        // Remaining ALU ops, borrow and carry.
        do_instr(8'h72, 4'h2, 4'h2, 5'b10000, 2);
        do_instr(8'h25, 4'hD, 4'h3, 5'b10001, 4);
        do_instr(8'h46, 4'hF, 4'h4, 5'b01000, 4);
        do_instr(8'h5A, 4'h5, 4'h5, 5'b01000, 4);
        do_instr(8'h3C, 4'h4, 4'h6, 5'b10000, 4);
        do_instr(8'h1E, 4'h2, 4'h7, 5'b10010, 4);

        // Reset in the middle of an ADD's EXEC phase aborts it.
        step_id++;
        instr_in = 8'h11;
        set_strobe(1'b1);
        @(negedge clk);
        set_strobe(1'b0);
        check("midrst_pre_opcode", 32'(alu_opcode), 32'h1);
        reset = 1'b0;
        #1;
        check("midrst_pc", 32'(pc_out), 32'd0);
        check("midrst_acc", 32'(acc_out), 32'd0);
        check("midrst_flag", 32'(flag_out), 32'd0);
        check("midrst_fetch_req", 32'(fetch_req), 32'd1);
        check("midrst_alu_opcode", 32'(alu_opcode), 32'd0);
        check("midrst_alu_b", 32'(alu_b), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("postrst_acc", 32'(acc_out), 32'd0);
        check("postrst_pc", 32'(pc_out), 32'd0);
        check("postrst_fetch_req", 32'(fetch_req), 32'd1);

`ifdef SINGLE_STEP_EN
        // Valid without step must not fetch.
        step_id++;
        instr_in    = 8'h77;
        instr_valid = 1'b1;
        step        = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("nostep_pc", 32'(pc_out), 32'd0);
            check("nostep_fetch_req", 32'(fetch_req), 32'd1);
        end
        instr_valid = 1'b0;
`endif

        // Halt freezes everything until reset.
        do_instr(8'h77, 4'h7, 4'h1, 5'b00000, 2);
        do_instr(8'hF0, 4'h7, 4'h2, 5'b00000, 2);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_fetch_req", 32'(fetch_req), 32'd0);
        step_id++;
        instr_in = 8'h71;
        set_strobe(1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("frozen_pc", 32'(pc_out), 32'd2);
            check("frozen_acc", 32'(acc_out), 32'd7);
            check("frozen_halted", 32'(halted), 32'd1);
            check("frozen_fetch_req", 32'(fetch_req), 32'd0);
        end
        set_strobe(1'b0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("unhalt_halted", 32'(halted), 32'd0);
        check("unhalt_fetch_req", 32'(fetch_req), 32'd1);
        check("unhalt_pc", 32'(pc_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
